// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch queue bus bundle: PC/imem request-response and decode handshake
interface if_fetch_queue_if;
  logic [31:0] pc_i;
  logic        ifu_go_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  // Queue side: consumes PC, memory responses, flush and decode ready.
  modport slave (
    input  pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, flush_i, id_ready_i,
    output ifu_go_o, imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
  );

  // Environment side: PC register, instruction memory and decode.
  modport master (
    output pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, flush_i, id_ready_i,
    input  ifu_go_o, imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
  );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - in-order instruction fetch queue between PC register and decode
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic            clk,
  input logic            reset,
  if_fetch_queue_if.slave fq
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [PTR_W:0]   r_alloc_ptr;
  logic [PTR_W:0]   r_fill_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [PTR_W:0]   r_discard_cnt;
  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic [PTR_W:0]   w_occ;
  logic [PTR_W:0]   w_inflight;
  logic [PTR_W:0]   w_discard_flush;
  logic [PTR_W-1:0] w_alloc_idx;
  logic [PTR_W-1:0] w_fill_idx;
  logic [PTR_W-1:0] w_rd_idx;
  logic             w_full;
  logic             w_discarding;
  logic             w_req;
  logic             w_grant;
  logic             w_drop;
  logic             w_fill;
  logic             w_valid;
  logic             w_pop;

  assign w_occ        = r_alloc_ptr - r_rd_ptr;
  assign w_inflight   = r_alloc_ptr - r_fill_ptr;
  assign w_alloc_idx  = r_alloc_ptr[PTR_W-1:0];
  assign w_fill_idx   = r_fill_ptr[PTR_W-1:0];
  assign w_rd_idx     = r_rd_ptr[PTR_W-1:0];

  // occ never exceeds DEPTH, so the wrap bit of occ alone marks "full".
  assign w_full       = w_occ[PTR_W];
  assign w_discarding = (r_discard_cnt != '0);

  // Request uses registered state only: a slot freed by a pop is reusable next cycle.
  assign w_req   = !reset && !fq.flush_i && !w_discarding && !w_full;
  assign w_grant = w_req && fq.imem_gnt_i;

  // Responses owed to a flushed stream are dropped before any fill happens.
  assign w_drop  = fq.imem_rvalid_i && w_discarding;
  assign w_fill  = fq.imem_rvalid_i && !w_discarding && (r_fill_ptr != r_alloc_ptr);

  assign w_valid = (w_occ != '0) && r_filled[w_rd_idx];
  assign w_pop   = w_valid && fq.id_ready_i;

  // Every response still owed after this cycle must be thrown away after a flush.
  assign w_discard_flush = r_discard_cnt + w_inflight - ((w_drop || w_fill) ? PTR_ONE : '0);

  assign fq.imem_req_o  = w_req;
  assign fq.imem_addr_o = fq.pc_i;
  assign fq.ifu_go_o    = w_grant || (fq.flush_i && !reset);
  assign fq.id_valid_o  = w_valid;
  assign fq.id_instr_o  = r_instr[w_rd_idx];
  assign fq.id_pc_o     = r_pc[w_rd_idx];

  // Pointer, filled-bit and discard bookkeeping; flush outranks grant, fill and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alloc_ptr   <= '0;
      r_fill_ptr    <= '0;
      r_rd_ptr      <= '0;
      r_discard_cnt <= '0;
      r_filled      <= '0;
    end else if (fq.flush_i) begin
      r_alloc_ptr   <= r_rd_ptr;
      r_fill_ptr    <= r_rd_ptr;
      r_filled      <= '0;
      r_discard_cnt <= w_discard_flush;
    end else begin
      if (w_grant) begin
        r_filled[w_alloc_idx] <= 1'b0;
        r_alloc_ptr           <= r_alloc_ptr + PTR_ONE;
      end
      if (w_fill) begin
        r_filled[w_fill_idx] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_filled[w_rd_idx] <= 1'b0;
        r_rd_ptr           <= r_rd_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_discard_cnt <= r_discard_cnt - PTR_ONE;
      end
    end
  end

  // Entry payload capture; contents only matter once the filled bit is set.
  always_ff @(posedge clk) begin
    if (!reset && !fq.flush_i) begin
      if (w_grant) begin
        r_pc[w_alloc_idx] <= fq.pc_i;
      end
      if (w_fill) begin
        r_instr[w_fill_idx] <= fq.imem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic reset;

  if_fetch_queue_if fq();

  if_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  logic        mem_hold;
  logic [31:0] redirect;
  logic        s_go, s_req, s_valid, s_grant, s_rv;
  logic [31:0] s_addr;
  int          n_grants;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic expect_pop(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // One clock: present memory response, sample at negedge, then advance PC and memory.
  task automatic step();
    logic [31:0] head;
    head = (mem_q.size() != 0) ? mem_q[0] : 32'h0;
    fq.imem_rvalid_i = !mem_hold && (mem_q.size() != 0);
    fq.imem_rdata_i  = {16'hC0DE, head[15:0]};
    @(negedge clk);
    s_go    = fq.ifu_go_o;
    s_req   = fq.imem_req_o;
    s_addr  = fq.imem_addr_o;
    s_valid = fq.id_valid_o;
    s_grant = fq.imem_req_o && fq.imem_gnt_i;
    s_rv    = fq.imem_rvalid_i;
    @(posedge clk);
    #1;
    if (reset) begin
      fq.pc_i = 32'h0;
      mem_q.delete();
    end else begin
      if (s_go) fq.pc_i = fq.flush_i ? redirect : fq.pc_i + 32'd4;
      if (s_rv) void'(mem_q.pop_front());
      if (s_grant) begin
        mem_q.push_back(s_addr);
        n_grants++;
      end
    end
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    mem_q.delete();
    mem_hold         = 1'b0;
    fq.pc_i          = 32'h0;
    fq.imem_gnt_i    = 1'b0;
    fq.flush_i       = 1'b0;
    fq.id_ready_i    = 1'b0;
    step();
    step();
    reset    = 1'b0;
    n_grants = 0;
  endtask

  task automatic drain(input string name);
    fq.imem_gnt_i = 1'b0;
    fq.id_ready_i = 1'b1;
    fq.flush_i    = 1'b0;
    mem_hold      = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every accepted head (outside a flush cycle) must match the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && fq.id_valid_o && fq.id_ready_i && !fq.flush_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got pc %h expected no output", fq.id_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", fq.id_pc_o, e.pc);
        chk("pop_instr", fq.id_instr_o, e.instr);
      end
    end
  end

  initial begin
    reset            = 1'b1;
    mem_hold         = 1'b0;
    redirect         = 32'h0;
    n_grants         = 0;
    fq.pc_i          = 32'h0;
    fq.imem_gnt_i    = 1'b0;
    fq.imem_rvalid_i = 1'b0;
    fq.imem_rdata_i  = 32'h0;
    fq.flush_i       = 1'b0;
    fq.id_ready_i    = 1'b0;

    // Reset: flush and grant ignored.
    fq.flush_i    = 1'b1;
    fq.imem_gnt_i = 1'b1;
    step();
    chk("rst_req", s_req, 1'b0);
    chk("rst_go", s_go, 1'b0);
    chk("rst_valid", s_valid, 1'b0);

    // Streaming at one response per cycle.
    do_reset();
    expect_pop(32'h00, 32'hC0DE_0000);
    expect_pop(32'h04, 32'hC0DE_0004);
    expect_pop(32'h08, 32'hC0DE_0008);
    expect_pop(32'h0C, 32'hC0DE_000C);
    expect_pop(32'h10, 32'hC0DE_0010);
    expect_pop(32'h14, 32'hC0DE_0014);
    fq.imem_gnt_i = 1'b1;
    fq.id_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stream_go", s_go, 1'b1);
      chk("stream_addr", s_addr, 32'(i * 4));
      chk("stream_valid", s_valid, (i >= 2) ? 1'b1 : 1'b0);
    end
    drain("stream_drain");

    // Full / backpressure.
    do_reset();
    expect_pop(32'h00, 32'hC0DE_0000);
    expect_pop(32'h04, 32'hC0DE_0004);
    expect_pop(32'h08, 32'hC0DE_0008);
    expect_pop(32'h0C, 32'hC0DE_000C);
    expect_pop(32'h10, 32'hC0DE_0010);
    fq.imem_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("full_grants", n_grants, 4);
    chk("full_req", s_req, 1'b0);
    chk("full_go", s_go, 1'b0);
    fq.id_ready_i = 1'b1;
    step();
    chk("full_pop_req", s_req, 1'b0);
    fq.id_ready_i = 1'b0;
    step();
    chk("full_refill_req", s_req, 1'b1);
    chk("full_refill_addr", s_addr, 32'h10);
    step();
    chk("full_again_req", s_req, 1'b0);
    chk("full_total_grants", n_grants, 5);
    drain("full_drain");

    // Memory stall.
    do_reset();
    expect_pop(32'h00, 32'hC0DE_0000);
    expect_pop(32'h04, 32'hC0DE_0004);
    expect_pop(32'h08, 32'hC0DE_0008);
    fq.imem_gnt_i = 1'b1;
    fq.id_ready_i = 1'b1;
    step();
    step();
    fq.imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_go", s_go, 1'b0);
      chk("stall_addr", s_addr, 32'h08);
    end
    fq.imem_gnt_i = 1'b1;
    step();
    chk("stall_go_grant", s_go, 1'b1);
    chk("stall_grants", n_grants, 3);
    drain("stall_drain");

    // Flush with two outstanding and one filled.
    do_reset();
    fq.imem_gnt_i = 1'b1;
    step();
    step();
    mem_hold = 1'b1;
    step();
    fq.imem_gnt_i = 1'b0;
    fq.flush_i    = 1'b1;
    redirect      = 32'h100;
    step();
    chk("flush_go", s_go, 1'b1);
    chk("flush_req", s_req, 1'b0);
    fq.flush_i    = 1'b0;
    mem_hold      = 1'b0;
    fq.imem_gnt_i = 1'b1;
    fq.id_ready_i = 1'b1;
    step();
    chk("flush_valid_after", s_valid, 1'b0);
    chk("flush_drop1_req", s_req, 1'b0);
    step();
    chk("flush_drop2_req", s_req, 1'b0);
    chk("flush_drop2_valid", s_valid, 1'b0);
    expect_pop(32'h100, 32'hC0DE_0100);
    step();
    chk("flush_resume_req", s_req, 1'b1);
    chk("flush_resume_addr", s_addr, 32'h100);
    drain("flush_drain");

    // Flush coinciding with a fill response and a pop.
    do_reset();
    fq.imem_gnt_i = 1'b1;
    step();
    step();
    fq.imem_gnt_i = 1'b0;
    fq.id_ready_i = 1'b1;
    fq.flush_i    = 1'b1;
    redirect      = 32'h200;
    step();
    chk("flush2_go", s_go, 1'b1);
    fq.flush_i = 1'b0;
    step();
    chk("flush2_valid_after", s_valid, 1'b0);
    chk("flush2_req", s_req, 1'b1);
    chk("flush2_addr", s_addr, 32'h200);
    expect_pop(32'h200, 32'hC0DE_0200);
    fq.imem_gnt_i = 1'b1;
    step();
    chk("flush2_grant_addr", s_addr, 32'h200);
    drain("flush2_drain");

    // Reset while full with outstanding responses.
    do_reset();
    fq.imem_gnt_i = 1'b1;
    step();
    step();
    mem_hold = 1'b1;
    step();
    step();
    chk("prerst_grants", n_grants, 4);
    do_reset();
    fq.imem_gnt_i = 1'b1;
    expect_pop(32'h00, 32'hC0DE_0000);
    step();
    chk("postrst_valid", s_valid, 1'b0);
    chk("postrst_req", s_req, 1'b1);
    chk("postrst_addr", s_addr, 32'h00);
    drain("postrst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Decoupling stage directly downstream of the PC register in the pipelined MIPS core.
- Issues in-order instruction-memory requests at the current PC and drives the PC register's advance enable.
- Buffers returned instructions with their PCs and presents them to decode through a valid/ready handshake.
- Supports a single-cycle flush for branch/jump redirects, discarding in-flight responses.

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH); pointers carry one extra wrap bit (PTR_W+1 bits).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc_i  in  32  current PC from PC register.
- ifu_go_o  out  1  PC register load enable.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address, equals pc_i.
- imem_gnt_i  in  1  memory accepts request this cycle.
- imem_rvalid_i  in  1  response valid; in-order; earliest one cycle after grant.
- imem_rdata_i  in  32  response instruction word.
- flush_i  in  1  redirect: drop all buffered and in-flight instructions.
- id_valid_o  out  1  head entry valid toward decode.
- id_instr_o  out  32  head instruction.
- id_pc_o  out  32  head PC.
- id_ready_i  in  1  decode consumes head when id_valid_o high.

Behaviour:
- Interface fixed: reset is reset, synchronous, active-high; clock is clk.

State:
- Entry array: pc[32], instr[32], filled bit.
- Pointers: alloc_ptr, fill_ptr, rd_ptr (PTR_W+1 bits).
- discard_cnt: PTR_W+1 bits.
- occ = alloc_ptr - rd_ptr.

Request:
- imem_req_o = !reset && !flush_i && discard_cnt==0 && occ<DEPTH, using registered state only. There is no same-cycle reuse of a slot freed by a pop.
- imem_addr_o = pc_i.
- Grant = imem_req_o && imem_gnt_i. On grant, entry[alloc_ptr] gets pc=pc_i and filled=0; alloc_ptr increments.
- ifu_go_o = grant || flush_i. The flush term lets the PC register load the redirect target from NPC.

Response:
- If imem_rvalid_i && discard_cnt!=0: drop the response and decrement discard_cnt.
- Else if imem_rvalid_i && fill_ptr!=alloc_ptr: entry[fill_ptr] gets instr=imem_rdata_i and filled=1; fill_ptr increments.
- Else (rvalid with nothing outstanding): ignore.

Output:
- id_valid_o = occ!=0 && entry[rd_ptr].filled, from registered state. There is no rvalid→output bypass.
- id_instr_o and id_pc_o come from entry[rd_ptr]; content is don't-care when id_valid_o=0.
- Pop = id_valid_o && id_ready_i. On pop, rd_ptr increments and the filled bit clears.
- Latency: grant at cycle t, rvalid at t+k (k≥1), id_valid_o high at t+k+1.

Flush (priority over grant, fill and pop in the same cycle):
- All three pointers set to the value of rd_ptr; all filled bits clear.
- discard_cnt += (alloc_ptr - fill_ptr) - (rvalid consumed as a fill this cycle ? 1 : 0). A response arriving in the flush cycle is dropped regardless.
- id_valid_o=0 in the cycle after a flush.
- Requests resume only once discard_cnt reaches 0.

Reset:
- Pointers=0, discard_cnt=0, all filled bits=0.
- id_valid_o=0, imem_req_o=0, ifu_go_o=0 (flush_i ignored during reset).
- Reset mid-operation abandons outstanding responses. The memory side must also be reset in the same cycle.

Boundaries:
- Full (occ==DEPTH): no request. The next request is possible the cycle after a pop.
- Wrap: pointers wrap modulo 2·DEPTH; full/empty is decided by the extra bit.
- Pop and fill in the same cycle on different entries: both take effect.

Test Plan:
- Streaming: reset, then pc_i advances 0x0,0x4,0x8 per ifu_go_o, gnt=1, rvalid one cycle after each grant → id_valid_o from cycle 3 with (pc,instr) = (0x0,I0),(0x4,I1),… in order; ifu_go_o high every cycle.
- Full/backpressure: id_ready_i=0, memory always grants/responds → exactly 4 grants. imem_req_o then stays 0 and ifu_go_o 0. Raising id_ready_i for one cycle → one new request the following cycle with pc_i=0x10.
- Memory stall: gnt=0 for 3 cycles → ifu_go_o=0 and PC held at 0x8, imem_addr_o=0x8 stable. Grant on the 4th cycle → one allocation.
- Flush with in-flight: 2 outstanding plus 1 filled, then flush_i → id_valid_o=0 next cycle, discard_cnt=2. The next two rvalid responses are dropped; the first post-flush request is issued at the redirect PC 0x100; the first delivered pc is 0x100.
- Flush coinciding with rvalid and pop: that response is dropped, the pop is ignored, and the queue is empty afterwards.
- Reset while full with outstanding responses → next cycle id_valid_o=0, imem_req_o=1 (if gnt), first delivered pc=0x0.
